reg_window_file: RTL and testbench
==================================

Name: reg_window_file

Overview:
- Parametrised SPARC-style windowed register file with NWINDOWS overlapping windows and WIDTH-bit registers.
- Two combinational read ports and one synchronous write port.
- Owns the current window pointer (CWP). Executes SAVE/RESTORE and raises window overflow/underflow traps against an externally supplied WIM.
- Sits between the control unit and the ALU/datapath.

Parameters:
- WIDTH, 32, register width in bits.
- NWINDOWS, 4, number of windows; legal range 2..32. Physical register count is 8 + 16*NWINDOWS.
- CWPW, $clog2(NWINDOWS) (minimum 1), width of the CWP.
- BYPASS, 1, when 1 a read port returns wr_data if it addresses the physical register being written this cycle.

Ports:
- Clk  in  1  system clock, rising edge.
- Clr  in  1  asynchronous, active-low clear.
- rs1  in  5  read port A logical address.
- rs2  in  5  read port B logical address.
- rd_a  out  WIDTH  read port A data.
- rd_b  out  WIDTH  read port B data.
- wr_en  in  1  write enable.
- rd  in  5  write logical address.
- wr_data  in  WIDTH  write data.
- win_op  in  2  window operation: 00 none, 01 SAVE, 10 RESTORE, 11 reserved (treated as none).
- cwp_wr_en  in  1  direct CWP load.
- cwp_wdata  in  CWPW  CWP load value.
- wim  in  NWINDOWS  window invalid mask.
- cwp  out  CWPW  current window pointer.
- trap_ovf  out  1  one-cycle pulse: SAVE refused.
- trap_unf  out  1  one-cycle pulse: RESTORE refused.

Behaviour:
- Reset: while Clr=0, all physical registers, cwp, trap_ovf and trap_unf are 0, asynchronously. Clr has priority over every in-flight operation; a SAVE or write in the cycle Clr deasserts is not applied unless a rising edge occurs with Clr=1.
- Mapping for window w, with B(w)=8+16w:
  - r0..r7 map to globals at physical 0..7.
  - r8..r15 (outs) map to B(w)+j.
  - r16..r23 (locals) map to B(w)+8+j.
  - r24..r31 (ins) map to B((w+1) mod NWINDOWS)+j.
  - Consequence: outs of window w are the ins of window w-1.
- Reads:
  - Combinational from the current cwp. Logical r0 always reads 0.
  - With BYPASS=1, a read whose physical index equals the write physical index (wr_en=1, rd!=0) returns wr_data.
  - With BYPASS=0, a written value becomes visible after the edge.
- Write:
  - On a rising edge with wr_en=1 and rd!=0, the physical register selected by rd under the pre-edge cwp is loaded.
  - Writes to r0 are discarded.
- Window ops, evaluated at the rising edge in priority order:
  1. cwp_wr_en=1: cwp<=cwp_wdata. win_op is ignored and no trap is raised. Values >= NWINDOWS load cwp_wdata mod NWINDOWS.
  2. SAVE: let n=(cwp-1) mod NWINDOWS. If wim[n]=1, cwp holds and trap_ovf=1 for the next cycle. Otherwise cwp<=n.
  3. RESTORE: let n=(cwp+1) mod NWINDOWS. If wim[n]=1, cwp holds and trap_unf=1. Otherwise cwp<=n.
- Wrap-around: both directions wrap modulo NWINDOWS; wrapping is not a trap on its own.
- Traps:
  - trap_ovf and trap_unf are registered and high for exactly one cycle per refused op.
  - Back-to-back refused ops produce back-to-back pulses.
  - trap_ovf and trap_unf are never both high.
- Simultaneous write and window op: the write uses the old cwp. The op changes cwp for the next cycle, so a value written to an out register is visible as an in register after SAVE.
- Non-power-of-two NWINDOWS: all cwp arithmetic uses explicit modulo, not natural overflow.

Decomposition:
- Shared package rwf_pkg holds:
  - win_op encodings WOP_NONE, WOP_SAVE, WOP_RESTORE;
  - region bases GLOBAL_BASE=0, OUT_OFS=0, LOCAL_OFS=8, WIN_STRIDE=16;
  - function phys_index(cwp, logical_addr, NWINDOWS).
- Sub-module rwf_window_ctl holds cwp, the modulo next-window arithmetic, the WIM check and the trap pulse registers.
- The top level holds the storage array, the three address translators and bypass.

Test Plan:
- Reset: hold Clr=0 with wr_en=1 and rd=5. Then cwp=0, rd_a=0 for all rs1, and trap_ovf=trap_unf=0.
- Overlap: at cwp=0, wim=0, write r9=0xA5A5_0001, then SAVE. cwp=3 (NWINDOWS=4), and reading rs1=25 returns 0xA5A5_0001. A following RESTORE gives cwp=0, and r9 still reads 0xA5A5_0001.
- Overflow: at cwp=0, wim=4'b1000, issue SAVE. cwp stays 0 and trap_ovf is high for exactly one cycle. With wim=0, RESTORE from cwp=3 wraps to cwp=0 with no trap.
- Underflow and priority:
  - At cwp=2, wim=4'b1000, RESTORE gives trap_unf=1 and cwp=2.
  - With cwp_wr_en=1, cwp_wdata=1 and win_op=SAVE in the same cycle: cwp=1 and no trap.
- Globals, r0 and bypass:
  - Write r3=0x1234 at cwp=0, then move to cwp=2: r3 reads 0x1234.
  - Write r0=0xFFFF: r0 reads 0.
  - With BYPASS=1, wr_en=1, rd=17, wr_data=0x77 and rs2=17 in the same cycle: rd_b=0x77 before the edge.
- Parameter sweep: with NWINDOWS=3 and WIDTH=16, eight consecutive SAVEs with wim=0 give the cwp sequence 2,1,0,2,1,0,2,1. Clr asserted mid-sequence returns cwp to 0 immediately.

Source files
------------

// File: rtl/reg_window_file_pkg.sv
// Shared window-op encodings, register-file region layout and logical->physical address mapping.
// Pure definitions: no latency, no backpressure.
package rwf_pkg;

  localparam logic [1:0] WOP_NONE    = 2'b00;
  localparam logic [1:0] WOP_SAVE    = 2'b01;
  localparam logic [1:0] WOP_RESTORE = 2'b10;

  localparam int unsigned GLOBAL_BASE = 0;
  localparam int unsigned NGLOBALS    = 8;
  localparam int unsigned OUT_OFS     = 0;
  localparam int unsigned LOCAL_OFS   = 8;
  localparam int unsigned WIN_STRIDE  = 16;

  // Ins of window w are the outs of window w+1, wrapping at nwindows.
  function automatic int unsigned phys_index(input int unsigned cwp,
                                             input logic [4:0]  addr,
                                             input int unsigned nwindows);
    int unsigned j;
    int unsigned w;
    int unsigned ofs;
    j   = 32'(addr[2:0]);
    w   = cwp;
    ofs = OUT_OFS;
    case (addr[4:3])
      2'd0:    return GLOBAL_BASE + j;
      2'd1:    ofs = OUT_OFS;
      2'd2:    ofs = LOCAL_OFS;
      default: w = (cwp + 1 == nwindows) ? 0 : cwp + 1;
    endcase
    return NGLOBALS + WIN_STRIDE * w + ofs + j;
  endfunction

endpackage

// File: rtl/reg_window_file_if.sv
// Control-unit <-> register-file bundle: read/write ports, window ops, CWP and traps.
// Reads are combinational, writes/window ops take effect at the next rising edge; no backpressure.
interface reg_window_file_if
  import rwf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4,
  parameter int CWPW     = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
);
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [WIDTH-1:0]    rd_a;
  logic [WIDTH-1:0]    rd_b;
  logic                wr_en;
  logic [4:0]          rd;
  logic [WIDTH-1:0]    wr_data;
  logic [1:0]          win_op;
  logic                cwp_wr_en;
  logic [CWPW-1:0]     cwp_wdata;
  logic [NWINDOWS-1:0] wim;
  logic [CWPW-1:0]     cwp;
  logic                trap_ovf;
  logic                trap_unf;

  modport master (
    output rs1, rs2, wr_en, rd, wr_data, win_op, cwp_wr_en, cwp_wdata, wim,
    input  rd_a, rd_b, cwp, trap_ovf, trap_unf
  );

  modport slave (
    input  rs1, rs2, wr_en, rd, wr_data, win_op, cwp_wr_en, cwp_wdata, wim,
    output rd_a, rd_b, cwp, trap_ovf, trap_unf
  );
endinterface

// File: rtl/reg_window_file_window_ctl.sv
// Current window pointer with modulo SAVE/RESTORE stepping, WIM check and one-cycle trap pulses.
// CWP and traps update one cycle after the op is presented; refused ops never stall.
module rwf_window_ctl
  import rwf_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int CWPW     = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [1:0]          win_op,
  input  logic                cwp_wr_en,
  input  logic [CWPW-1:0]     cwp_wdata,
  input  logic [NWINDOWS-1:0] wim,
  output logic [CWPW-1:0]     cwp,
  output logic                trap_ovf,
  output logic                trap_unf
);
  localparam int unsigned     NW_U = NWINDOWS;
  localparam logic [CWPW-1:0] LAST = CWPW'(NWINDOWS - 1);

  logic [CWPW-1:0] cwp_q, cwp_d;
  logic [CWPW-1:0] cwp_dec, cwp_inc, cwp_load;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // Explicit wrap so non-power-of-two window counts never alias.
  always_comb begin
    cwp_dec  = (cwp_q == '0)   ? LAST : cwp_q - CWPW'(1);
    cwp_inc  = (cwp_q == LAST) ? '0   : cwp_q + CWPW'(1);
    cwp_load = CWPW'(32'(cwp_wdata) % NW_U);
    cwp_d    = cwp_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (cwp_wr_en) begin
      cwp_d = cwp_load;
    end else begin
      case (win_op)
        WOP_SAVE: begin
          if (wim[cwp_dec]) ovf_d = 1'b1;
          else              cwp_d = cwp_dec;
        end
        WOP_RESTORE: begin
          if (wim[cwp_inc]) unf_d = 1'b1;
          else              cwp_d = cwp_inc;
        end
        WOP_NONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      cwp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cwp      = cwp_q;
  assign trap_ovf = ovf_q;
  assign trap_unf = unf_q;
endmodule

// File: rtl/reg_window_file.sv
// Windowed register file: overlapping windows, two combinational read ports, one synchronous write port.
// Reads are zero-latency (optional same-cycle write bypass), writes land at the next edge; no backpressure.
module reg_window_file
  import rwf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4,
  parameter int CWPW     = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1,
  parameter int BYPASS   = 1
) (
  input  logic               Clk,
  input  logic               Clr,
  reg_window_file_if.slave   bus
);
  localparam int NREGS = NGLOBALS + WIN_STRIDE * NWINDOWS;
  localparam int PW    = $clog2(NREGS);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic [PW-1:0]    idx_a, idx_b, idx_w;
  logic [CWPW-1:0]  cwp;
  logic             wr_fire;

  rwf_window_ctl #(
    .NWINDOWS (NWINDOWS),
    .CWPW     (CWPW)
  ) u_window_ctl (
    .Clk       (Clk),
    .Clr       (Clr),
    .win_op    (bus.win_op),
    .cwp_wr_en (bus.cwp_wr_en),
    .cwp_wdata (bus.cwp_wdata),
    .wim       (bus.wim),
    .cwp       (cwp),
    .trap_ovf  (bus.trap_ovf),
    .trap_unf  (bus.trap_unf)
  );

  assign bus.cwp = cwp;

  always_comb begin
    idx_a = PW'(phys_index(32'(cwp), bus.rs1, NWINDOWS));
    idx_b = PW'(phys_index(32'(cwp), bus.rs2, NWINDOWS));
    idx_w = PW'(phys_index(32'(cwp), bus.rd,  NWINDOWS));
  end

  // No write is in flight while clear is held, so nothing to bypass then either.
  assign wr_fire = bus.wr_en && (bus.rd != 5'd0) && Clr;

  always_comb begin
    rf_d = rf_q;
    if (wr_fire) rf_d[idx_w] = bus.wr_data;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    bus.rd_a = rf_q[idx_a];
    bus.rd_b = rf_q[idx_b];
    if (BYPASS != 0 && wr_fire && idx_a == idx_w) bus.rd_a = bus.wr_data;
    if (BYPASS != 0 && wr_fire && idx_b == idx_w) bus.rd_b = bus.wr_data;
    if (bus.rs1 == 5'd0) bus.rd_a = '0;
    if (bus.rs2 == 5'd0) bus.rd_b = '0;
  end
endmodule

// File: tb/tb_reg_window_file.sv
// Bench for reg_window_file: a 4-window/32-bit instance and a 3-window/16-bit instance
// checked every cycle against a storage-location model, plus directed literal expectations.
module tb_reg_window_file;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  reg_window_file_if #(.WIDTH(32), .NWINDOWS(4), .CWPW(2)) ifa();
  reg_window_file_if #(.WIDTH(16), .NWINDOWS(3), .CWPW(2)) ifb();

  reg_window_file #(.WIDTH(32), .NWINDOWS(4), .CWPW(2), .BYPASS(1)) dut_a (
    .Clk (Clk), .Clr (clr_a), .bus (ifa.slave)
  );
  reg_window_file #(.WIDTH(16), .NWINDOWS(3), .CWPW(2), .BYPASS(1)) dut_b (
    .Clk (Clk), .Clr (clr_b), .bus (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: storage addressed by location key (globals 0..7, outs 100+, locals 200+).
  logic [31:0] mem [2][300];
  int          mcwp [2];
  logic        mov  [2];
  logic        mun  [2];

  function automatic int nw(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int loc_key(int k, int w, logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai < 8)  return ai;
    if (ai < 16) return 100 + w * 8 + (ai - 8);
    if (ai < 24) return 200 + w * 8 + (ai - 16);
    return 100 + ((w + 1) % nw(k)) * 8 + (ai - 24);
  endfunction

  task automatic model_reset(int k);
    for (int i = 0; i < 300; i++) mem[k][i] = '0;
    mcwp[k] = 0;
    mov[k]  = 1'b0;
    mun[k]  = 1'b0;
  endtask

  task automatic model_edge(int k, logic we, logic [4:0] rd, logic [31:0] wd, logic [1:0] op,
                            logic cwe, logic [31:0] cwd, logic [31:0] wim);
    int n;
    int nxt;
    n      = nw(k);
    mov[k] = 1'b0;
    mun[k] = 1'b0;
    if (we && rd != 5'd0) mem[k][loc_key(k, mcwp[k], rd)] = wd;
    if (cwe) begin
      mcwp[k] = int'(cwd) % n;
    end else if (op == 2'b01) begin
      nxt = (mcwp[k] + n - 1) % n;
      if (wim[nxt]) mov[k] = 1'b1;
      else          mcwp[k] = nxt;
    end else if (op == 2'b10) begin
      nxt = (mcwp[k] + 1) % n;
      if (wim[nxt]) mun[k] = 1'b1;
      else          mcwp[k] = nxt;
    end
  endtask

  function automatic logic [31:0] exp_read(int k, logic [4:0] a, logic clr, logic we,
                                           logic [4:0] rd, logic [31:0] wd);
    if (a == 5'd0) return '0;
    if (clr && we && rd != 5'd0 && loc_key(k, mcwp[k], a) == loc_key(k, mcwp[k], rd)) return wd;
    return mem[k][loc_key(k, mcwp[k], a)];
  endfunction

  task automatic expect_eq(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clr_a) model_reset(0);
  always @(negedge clr_b) model_reset(1);

  always @(posedge Clk) begin
    if (clr_a) model_edge(0, ifa.wr_en, ifa.rd, 32'(ifa.wr_data), ifa.win_op,
                          ifa.cwp_wr_en, 32'(ifa.cwp_wdata), 32'(ifa.wim));
    if (clr_b) model_edge(1, ifb.wr_en, ifb.rd, 32'(ifb.wr_data), ifb.win_op,
                          ifb.cwp_wr_en, 32'(ifb.cwp_wdata), 32'(ifb.wim));
  end

  always @(negedge Clk) begin
    expect_eq("a.rd_a", 32'(ifa.rd_a), exp_read(0, ifa.rs1, clr_a, ifa.wr_en, ifa.rd, 32'(ifa.wr_data)));
    expect_eq("a.rd_b", 32'(ifa.rd_b), exp_read(0, ifa.rs2, clr_a, ifa.wr_en, ifa.rd, 32'(ifa.wr_data)));
    expect_eq("a.cwp", 32'(ifa.cwp), 32'(mcwp[0]));
    expect_eq("a.trap_ovf", 32'(ifa.trap_ovf), 32'(mov[0]));
    expect_eq("a.trap_unf", 32'(ifa.trap_unf), 32'(mun[0]));
    expect_eq("a.trap_both", 32'(ifa.trap_ovf & ifa.trap_unf), 32'd0);
    expect_eq("b.rd_a", 32'(ifb.rd_a), exp_read(1, ifb.rs1, clr_b, ifb.wr_en, ifb.rd, 32'(ifb.wr_data)));
    expect_eq("b.rd_b", 32'(ifb.rd_b), exp_read(1, ifb.rs2, clr_b, ifb.wr_en, ifb.rd, 32'(ifb.wr_data)));
    expect_eq("b.cwp", 32'(ifb.cwp), 32'(mcwp[1]));
    expect_eq("b.trap_ovf", 32'(ifb.trap_ovf), 32'(mov[1]));
    expect_eq("b.trap_unf", 32'(ifb.trap_unf), 32'(mun[1]));
  end

  task automatic cyc();
    @(posedge Clk);
    #3;
  endtask

  task automatic idle_a();
    ifa.wr_en     = 1'b0;
    ifa.win_op    = 2'b00;
    ifa.cwp_wr_en = 1'b0;
  endtask

  task automatic idle_b();
    ifb.wr_en     = 1'b0;
    ifb.win_op    = 2'b00;
    ifb.cwp_wr_en = 1'b0;
  endtask

  int exp_seq [8] = '{2, 1, 0, 2, 1, 0, 2, 1};

  initial begin
    model_reset(0);
    model_reset(1);
    ifa.rs1 = 5'd0; ifa.rs2 = 5'd0; ifa.wr_en = 1'b1; ifa.rd = 5'd5;
    ifa.wr_data = 32'hDEAD_BEEF; ifa.win_op = 2'b00; ifa.cwp_wr_en = 1'b0;
    ifa.cwp_wdata = 2'd0; ifa.wim = 4'b0000;
    ifb.rs1 = 5'd0; ifb.rs2 = 5'd0; ifb.wr_en = 1'b0; ifb.rd = 5'd0;
    ifb.wr_data = 16'h0; ifb.win_op = 2'b00; ifb.cwp_wr_en = 1'b0;
    ifb.cwp_wdata = 2'd0; ifb.wim = 3'b000;

    // Reset held with a pending write to r5: everything reads zero.
    for (int i = 0; i < 32; i++) begin
      cyc();
      ifa.rs1 = 5'(i);
      ifa.rs2 = 5'(31 - i);
      #1;
      expect_eq("rst_rd_a", 32'(ifa.rd_a), 32'd0);
    end
    expect_eq("rst_cwp", 32'(ifa.cwp), 32'd0);
    expect_eq("rst_ovf", 32'(ifa.trap_ovf), 32'd0);
    expect_eq("rst_unf", 32'(ifa.trap_unf), 32'd0);
    clr_a = 1'b1;
    idle_a();
    cyc();

    // Out of window 0 becomes in of window 3 after SAVE.
    ifa.wr_en = 1'b1; ifa.rd = 5'd9; ifa.wr_data = 32'hA5A5_0001;
    cyc();
    idle_a(); ifa.win_op = 2'b01;
    cyc();
    expect_eq("save_cwp", 32'(ifa.cwp), 32'd3);
    idle_a(); ifa.rs1 = 5'd25; #1;
    expect_eq("overlap_r25", 32'(ifa.rd_a), 32'hA5A5_0001);
    ifa.win_op = 2'b10;
    cyc();
    expect_eq("restore_cwp", 32'(ifa.cwp), 32'd0);
    idle_a(); ifa.rs1 = 5'd9; #1;
    expect_eq("overlap_r9", 32'(ifa.rd_a), 32'hA5A5_0001);

    // Overflow refused, then a clean wrapping RESTORE 3 -> 0.
    ifa.wim = 4'b1000; ifa.win_op = 2'b01;
    cyc();
    expect_eq("ovf_cwp", 32'(ifa.cwp), 32'd0);
    expect_eq("ovf_pulse", 32'(ifa.trap_ovf), 32'd1);
    idle_a();
    cyc();
    expect_eq("ovf_one_cycle", 32'(ifa.trap_ovf), 32'd0);
    ifa.wim = 4'b0000; ifa.cwp_wr_en = 1'b1; ifa.cwp_wdata = 2'd3;
    cyc();
    expect_eq("load3", 32'(ifa.cwp), 32'd3);
    idle_a(); ifa.win_op = 2'b10;
    cyc();
    expect_eq("wrap_cwp", 32'(ifa.cwp), 32'd0);
    expect_eq("wrap_no_unf", 32'(ifa.trap_unf), 32'd0);

    // Underflow, back-to-back pulses, then load-over-SAVE priority.
    idle_a(); ifa.cwp_wr_en = 1'b1; ifa.cwp_wdata = 2'd2;
    cyc();
    idle_a(); ifa.wim = 4'b1000; ifa.win_op = 2'b10;
    cyc();
    expect_eq("unf_pulse", 32'(ifa.trap_unf), 32'd1);
    expect_eq("unf_cwp", 32'(ifa.cwp), 32'd2);
    cyc();
    expect_eq("unf_b2b", 32'(ifa.trap_unf), 32'd1);
    idle_a();
    cyc();
    expect_eq("unf_clear", 32'(ifa.trap_unf), 32'd0);
    ifa.wim = 4'b0010; ifa.cwp_wr_en = 1'b1; ifa.cwp_wdata = 2'd1; ifa.win_op = 2'b01;
    cyc();
    expect_eq("prio_cwp", 32'(ifa.cwp), 32'd1);
    expect_eq("prio_no_ovf", 32'(ifa.trap_ovf), 32'd0);
    idle_a(); ifa.wim = 4'b0000;

    // Globals are shared by every window.
    ifa.cwp_wr_en = 1'b1; ifa.cwp_wdata = 2'd0;
    cyc();
    idle_a(); ifa.wr_en = 1'b1; ifa.rd = 5'd3; ifa.wr_data = 32'h0000_1234;
    cyc();
    idle_a(); ifa.cwp_wr_en = 1'b1; ifa.cwp_wdata = 2'd2;
    cyc();
    idle_a(); ifa.rs1 = 5'd3; #1;
    expect_eq("global_r3", 32'(ifa.rd_a), 32'h0000_1234);

    // r0 ignores writes.
    ifa.wr_en = 1'b1; ifa.rd = 5'd0; ifa.wr_data = 32'h0000_FFFF; ifa.rs1 = 5'd0; #1;
    expect_eq("r0_same_cycle", 32'(ifa.rd_a), 32'd0);
    cyc();
    idle_a(); #1;
    expect_eq("r0_after", 32'(ifa.rd_a), 32'd0);

    // Same-cycle bypass then stored value.
    ifa.wr_en = 1'b1; ifa.rd = 5'd17; ifa.wr_data = 32'h0000_0077; ifa.rs2 = 5'd17; #1;
    expect_eq("bypass_rd_b", 32'(ifa.rd_b), 32'h0000_0077);
    cyc();
    idle_a(); #1;
    expect_eq("stored_rd_b", 32'(ifa.rd_b), 32'h0000_0077);

    // Write uses the old window while SAVE moves the pointer.
    ifa.wr_en = 1'b1; ifa.rd = 5'd10; ifa.wr_data = 32'hCAFE_F00D; ifa.win_op = 2'b01;
    cyc();
    expect_eq("wsave_cwp", 32'(ifa.cwp), 32'd1);
    idle_a(); ifa.rs1 = 5'd26; #1;
    expect_eq("wsave_r26", 32'(ifa.rd_a), 32'hCAFE_F00D);
    expect_eq("wsave_local", 32'(ifa.rd_b), 32'd0);

    // Three-window instance: modulo stepping and async clear.
    clr_b = 1'b1;
    idle_b();
    cyc();
    ifb.win_op = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_eq("n3_save_seq", 32'(ifb.cwp), 32'(exp_seq[i]));
    end
    cyc();
    cyc();
    expect_eq("n3_before_clr", 32'(ifb.cwp), 32'd2);
    clr_b = 1'b0; #1;
    expect_eq("n3_async_clr", 32'(ifb.cwp), 32'd0);
    cyc();
    expect_eq("n3_held_clr", 32'(ifb.cwp), 32'd0);
    clr_b = 1'b1;
    cyc();
    expect_eq("n3_first_save", 32'(ifb.cwp), 32'd2);
    idle_b(); ifb.cwp_wr_en = 1'b1; ifb.cwp_wdata = 2'd3;
    cyc();
    expect_eq("n3_load_mod", 32'(ifb.cwp), 32'd0);
    idle_b(); ifb.wr_en = 1'b1; ifb.rd = 5'd15; ifb.wr_data = 16'h1357;
    cyc();
    idle_b(); ifb.cwp_wr_en = 1'b1; ifb.cwp_wdata = 2'd2;
    cyc();
    idle_b(); ifb.rs1 = 5'd31; #1;
    expect_eq("n3_wrap_ins", 32'(ifb.rd_a), 32'h0000_1357);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
